// File: rtl/psdram_frame_writer.sv
// Raster-order PSDRAM write sequencer for the VGA frame buffer.
// Each 16-bit pixel word becomes one asynchronous write cycle driven by registered strobes.
module psdram_frame_writer #(
    parameter int WORDS_PER_LINE = 320,
    parameter int VLINES         = 480,
    parameter int LINE_STRIDE    = 640,
    parameter int WR_CYCLES      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        mem_grant,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic [22:0] MemAdr,
    output logic [15:0] MemDataOut,
    output logic        MemDataOE,
    output logic        RamCE,
    output logic        MemWR,
    output logic        MemOE,
    output logic        RamLB,
    output logic        RamUB,
    output logic        busy,
    output logic        frame_done
);

    // state   | meaning
    // S_IDLE  | bus released; pix_ready follows mem_grant; accept latches addr/data
    // S_SETUP | RamCE low, data driven, MemWR still high (address/data setup)
    // S_WRITE | MemWR low for WR_CYCLES clocks, timed by wr_cnt down-counter
    // S_HOLD  | MemWR high, RamCE low, data held; advance raster address
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam int COL_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int ROW_W = (VLINES > 1) ? $clog2(VLINES) : 1;
    localparam int WR_W  = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WORDS_PER_LINE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(VLINES - 1);
    localparam logic [22:0]      STRIDE   = 23'(LINE_STRIDE);
    localparam logic [WR_W-1:0]  WR_LOAD  = WR_W'(WR_CYCLES - 1);

    logic [1:0]       state;
    logic [WR_W-1:0]  wr_cnt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [22:0]      line_base;
    logic             fs_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wr_cnt     <= '0;
            col        <= '0;
            row        <= '0;
            line_base  <= '0;
            fs_pending <= 1'b0;
            pix_ready  <= 1'b0;
            MemAdr     <= '0;
            MemDataOut <= '0;
            MemDataOE  <= 1'b0;
            RamCE      <= 1'b1;
            MemWR      <= 1'b1;
            MemOE      <= 1'b1;
            RamLB      <= 1'b0;
            RamUB      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // A restart arriving mid-cycle waits until the write has finished.
            if (frame_start && state != S_IDLE)
                fs_pending <= 1'b1;

            case (state)
                S_IDLE: begin
                    pix_ready  <= mem_grant;
                    fs_pending <= 1'b0;
                    if (frame_start) begin
                        col       <= '0;
                        row       <= '0;
                        line_base <= '0;
                    end
                    if (pix_valid && pix_ready) begin
                        MemAdr     <= frame_start ? 23'd0 : line_base + 23'(col);
                        MemDataOut <= pix_data;
                        MemDataOE  <= 1'b1;
                        RamCE      <= 1'b0;
                        busy       <= 1'b1;
                        pix_ready  <= 1'b0;
                        state      <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    MemWR  <= 1'b0;
                    wr_cnt <= WR_LOAD;
                    state  <= S_WRITE;
                end

                S_WRITE: begin
                    if (wr_cnt == '0) begin
                        MemWR <= 1'b1;
                        state <= S_HOLD;
                    end else begin
                        wr_cnt <= wr_cnt - 1'b1;
                    end
                end

                S_HOLD: begin
                    RamCE      <= 1'b1;
                    MemDataOE  <= 1'b0;
                    busy       <= 1'b0;
                    pix_ready  <= mem_grant;
                    fs_pending <= 1'b0;
                    state      <= S_IDLE;
                    if (fs_pending || frame_start) begin
                        col       <= '0;
                        row       <= '0;
                        line_base <= '0;
                    end else if (col == COL_LAST) begin
                        col <= '0;
                        if (row == ROW_LAST) begin
                            row        <= '0;
                            line_base  <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            row       <= row + 1'b1;
                            line_base <= line_base + STRIDE;
                        end
                    end else begin
                        col <= col + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psdram_frame_writer.sv
// Directed bench for psdram_frame_writer, using a reduced 4x3 frame (stride 8) so a
// whole frame, the row wrap and the frame wrap fit in a short run.
module tb_psdram_frame_writer;

    localparam int WPL = 4;
    localparam int VL  = 3;
    localparam int STR = 8;
    localparam int WRC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        mem_grant = 1'b1;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = '0;
    logic        pix_ready;
    logic [22:0] MemAdr;
    logic [15:0] MemDataOut;
    logic        MemDataOE, RamCE, MemWR, MemOE, RamLB, RamUB, busy, frame_done;

    int checks = 0;
    int errors = 0;
    int fd_total = 0;

    psdram_frame_writer #(
        .WORDS_PER_LINE(WPL),
        .VLINES(VL),
        .LINE_STRIDE(STR),
        .WR_CYCLES(WRC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_start(frame_start),
        .mem_grant(mem_grant),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .pix_ready(pix_ready),
        .MemAdr(MemAdr),
        .MemDataOut(MemDataOut),
        .MemDataOE(MemDataOE),
        .RamCE(RamCE),
        .MemWR(MemWR),
        .MemOE(MemOE),
        .RamLB(RamLB),
        .RamUB(RamUB),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (pix_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("ready_wait", {31'd0, pix_ready}, 32'd1);
    endtask

    // Sends one word and follows the bus until RamCE releases.
    task automatic write_word(input logic [15:0] d, input logic [22:0] exp_adr,
                              input int fs_cycle, input int drop_cycle,
                              input bit fs_acc, input bit exp_ready);
        int n = 0;
        int wr_low = 0;
        int ce_low = 0;
        int unstable = 0;
        wait_ready();
        pix_valid   = 1'b1;
        pix_data    = d;
        frame_start = fs_acc;
        tick();
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        check("adr", {9'd0, MemAdr}, {9'd0, exp_adr});
        check("data", {16'd0, MemDataOut}, {16'd0, d});
        check("setup_wr_high", {31'd0, MemWR}, 32'd1);
        check("busy", {31'd0, busy}, 32'd1);
        while (RamCE === 1'b0 && n < 20) begin
            if (MemAdr !== exp_adr || MemDataOut !== d || MemDataOE !== 1'b1) unstable++;
            if (MemWR === 1'b0) wr_low++;
            ce_low++;
            frame_start = (n == fs_cycle);
            if (n == drop_cycle) mem_grant = 1'b0;
            tick();
            frame_start = 1'b0;
            if (frame_done === 1'b1) fd_total++;
            n++;
        end
        check("wr_low_cycles", wr_low, WRC);
        check("ce_low_cycles", ce_low, WRC + 2);
        check("stable", unstable, 0);
        check("oe_release", {31'd0, MemDataOE}, 32'd0);
        check("ready_return", {31'd0, pix_ready}, {31'd0, exp_ready});
    endtask

    initial begin
        // Reset values
        reset = 1'b1;
        tick();
        tick();
        check("rst_MemWR", {31'd0, MemWR}, 32'd1);
        check("rst_MemOE", {31'd0, MemOE}, 32'd1);
        check("rst_RamCE", {31'd0, RamCE}, 32'd1);
        check("rst_RamLB", {31'd0, RamLB}, 32'd0);
        check("rst_RamUB", {31'd0, RamUB}, 32'd0);
        check("rst_MemAdr", {9'd0, MemAdr}, 32'd0);
        check("rst_MemDataOut", {16'd0, MemDataOut}, 32'd0);
        check("rst_MemDataOE", {31'd0, MemDataOE}, 32'd0);
        check("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        tick();

        // First word, then the rest of the frame in raster order
        write_word(16'hE31C, 23'd0, -1, -1, 1'b0, 1'b1);
        for (int i = 1; i < WPL * VL; i++) begin
            if (i == WPL * VL - 1) check("no_early_frame_done", fd_total, 0);
            write_word(16'(16'h1000 + i), 23'((i / WPL) * STR + (i % WPL)), -1, -1, 1'b0, 1'b1);
        end
        check("frame_done_once", fd_total, 1);

        // Frame wrap, then restart during WRITE of the word at address 9
        write_word(16'hA000, 23'd0, -1, -1, 1'b0, 1'b1);
        write_word(16'hA001, 23'd1, -1, -1, 1'b0, 1'b1);
        write_word(16'hA002, 23'd2, -1, -1, 1'b0, 1'b1);
        write_word(16'hA003, 23'd3, -1, -1, 1'b0, 1'b1);
        write_word(16'hA004, 23'd8, -1, -1, 1'b0, 1'b1);
        write_word(16'hA005, 23'd9, 2, -1, 1'b0, 1'b1);
        write_word(16'hB000, 23'd0, -1, -1, 1'b0, 1'b1);
        check("no_frame_done_on_restart", fd_total, 1);

        // Grant dropped mid-WRITE still gives a full pulse; ready stays low afterwards
        write_word(16'hB001, 23'd1, 2, 2, 1'b0, 1'b0);
        check("fs_no_effect_before", fd_total, 1);
        mem_grant = 1'b1;
        tick();
        check("ready_regrant", {31'd0, pix_ready}, 32'd1);

        // No grant: valid word is refused and the bus stays idle
        mem_grant = 1'b0;
        tick();
        pix_valid = 1'b1;
        pix_data  = 16'hDEAD;
        tick();
        tick();
        tick();
        check("nogrant_ready", {31'd0, pix_ready}, 32'd0);
        check("nogrant_RamCE", {31'd0, RamCE}, 32'd1);
        check("nogrant_busy", {31'd0, busy}, 32'd0);
        pix_valid = 1'b0;
        mem_grant = 1'b1;
        tick();

        // The word write_word(B001) advanced to address 2 only if the mid-write restart
        // was ignored; frame_start in HOLD cleared it, so counters sit at 0 here.
        write_word(16'hC000, 23'd0, -1, -1, 1'b0, 1'b1);
        write_word(16'hC001, 23'd1, -1, -1, 1'b0, 1'b1);
        write_word(16'hC002, 23'd0, -1, -1, 1'b1, 1'b1);
        write_word(16'hC003, 23'd1, -1, -1, 1'b0, 1'b1);

        // Reset in the middle of WRITE
        wait_ready();
        pix_valid = 1'b1;
        pix_data  = 16'h5A5A;
        tick();
        pix_valid = 1'b0;
        check("rstw_adr", {9'd0, MemAdr}, 32'd2);
        tick();
        check("rstw_in_write", {31'd0, MemWR}, 32'd0);
        reset = 1'b1;
        tick();
        check("rstw_MemWR", {31'd0, MemWR}, 32'd1);
        check("rstw_RamCE", {31'd0, RamCE}, 32'd1);
        check("rstw_MemDataOE", {31'd0, MemDataOE}, 32'd0);
        check("rstw_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick();
        write_word(16'h0F0F, 23'd0, -1, -1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psdram_frame_writer.md
# psdram_frame_writer

Writes pixel words into the PSDRAM frame buffer that the VGA scan-out path reads. Accepts 16-bit words (two RGB332 pixels, even pixel in [15:8]) over a valid/ready handshake. Sequences asynchronous PSDRAM write cycles with registered control strobes. Auto-increments the frame address in raster order, using the same row stride as the scan-out reader.

## Interface
Parameters:
- WORDS_PER_LINE, 320: 16-bit words written per line (640 pixels / 2).
- VLINES, 480: lines per frame.
- LINE_STRIDE, 640: word-address distance between line starts; must match the reader.
- WR_CYCLES, 4: clk cycles MemWR is held low (4 × 20 ns = 80 ns at 50 MHz); minimum 1.

Ports:
- clk  in  1  system clock (50 MHz); the only clock.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  single-cycle pulse; restarts the address at row 0, col 0.
- mem_grant  in  1  bus arbitration; writer may start a cycle only while high.
- pix_valid  in  1  source has a word.
- pix_data  in  16  word to write.
- pix_ready  out  1  writer accepts a word this cycle.
- MemAdr  out  23  PSDRAM word address.
- MemDataOut  out  16  write data.
- MemDataOE  out  1  enables the data-bus tristate driver.
- RamCE  out  1  chip enable, active-low.
- MemWR  out  1  write enable, active-low.
- MemOE  out  1  output enable, active-low; held 1 by this block.
- RamLB, RamUB  out  1 each  byte enables, active-low; held 0 (full word).
- busy  out  1  high from accept until return to IDLE.
- frame_done  out  1  one-cycle pulse after the last word of a frame is written.

## Operation
- All outputs are registered. Reset values:
  - MemWR=1, MemOE=1, RamCE=1, RamLB=0, RamUB=0.
  - MemAdr=0, MemDataOut=0, MemDataOE=0.
  - pix_ready=0, busy=0, frame_done=0.
  - Counters row=0, col=0, line_base=0.
- FSM states: IDLE, SETUP, WRITE, HOLD.
- IDLE:
  - pix_ready = mem_grant.
  - On pix_valid&&pix_ready: latch pix_data into MemDataOut, set MemAdr=line_base+col, go to SETUP.
- SETUP (1 cycle): RamCE=0, MemDataOE=1, MemWR=1 (address/data setup).
- WRITE (WR_CYCLES cycles): MemWR=0, RamCE=0, MemDataOE=1. A down-counter sets the duration.
- HOLD (1 cycle):
  - MemWR=1, RamCE=0, data still driven (hold time).
  - Advance the address counters, then go to IDLE.
  - On exit: RamCE=1, MemDataOE=0.
- Address arithmetic:
  - No multiplier. line_base increments by LINE_STRIDE on each row advance.
  - col wraps from WORDS_PER_LINE-1 to 0 and increments row.
  - After row=VLINES-1, col=WORDS_PER_LINE-1: row, col and line_base all return to 0, and frame_done pulses one cycle on the HOLD→IDLE edge.
- frame_start:
  - In IDLE: counters clear that cycle. A word accepted in the same cycle is written to address 0.
  - In SETUP/WRITE/HOLD: the write completes at its original address. The start is latched as pending and clears the counters on HOLD exit, overriding the normal advance. No frame_done is issued for that transition.
- mem_grant is sampled only in IDLE. Deassertion during a write does not abort it (an async write cannot be cut short).
- Reset mid-write: on the next edge, return to IDLE with all reset values. The in-flight word is discarded.

## Timing
- Accept at edge N; the bus takes these values at:
  - N+1: MemAdr/MemDataOut valid, RamCE low.
  - N+2 … N+1+WR_CYCLES: MemWR low.
  - N+2+WR_CYCLES: MemWR high (HOLD).
  - N+3+WR_CYCLES: RamCE high, MemDataOE low.
- pix_ready returns high at N+3+WR_CYCLES (if mem_grant). This gives a throughput of one word per WR_CYCLES+3 cycles (7 at default).
- Address and data are stable from SETUP through HOLD inclusive. MemWR never falls in the same cycle RamCE falls.
- busy is high from N+1 through HOLD.

## Test plan
- Reset, then a single word 0xE31C with pix_valid held -> MemAdr=0, data 0xE31C, MemWR low exactly 4 cycles, RamCE low 6 cycles, next pix_ready 7 cycles after accept.
- 321 consecutive words -> the 320th word goes to address 319; the 321st goes to address 640 (row 1, stride applied).
- Full frame of 153600 words -> last address 479*640+319=306879; frame_done pulses once; next word goes to address 0.
- frame_start during WRITE of word at address 5 -> that write completes at 5; next word goes to 0; no frame_done.
- mem_grant=0 with pix_valid=1 -> pix_ready=0, RamCE stays 1. Drop mem_grant mid-WRITE -> full MemWR pulse still issued.
- Assert reset during WRITE -> next cycle MemWR=1, RamCE=1, MemDataOE=0, busy=0. The following word goes to address 0.
